subneg_loader: RTL
==================

SUBNEG_LOADER -- requirements
Module: subneg_loader

Interface
REQ-001 Parameter: WIDTH, default 8, data word and memory address width.
REQ-002 Clock and reset: one clock; reset is synchronous and active-high.
REQ-003 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: rst  input  1  synchronous, active-high reset.
REQ-005 Port: start  input  1  single-cycle request to begin a load session.
REQ-006 Port: in_valid  input  1  host byte valid.
REQ-007 Port: in_data  input  WIDTH  host byte.
REQ-008 Port: in_ready  output  1  loader accepts in_data this cycle.
REQ-009 Port: mem_we  output  1  write strobe to core program/data memory.
REQ-010 Port: mem_addr  output  WIDTH  write address.
REQ-011 Port: mem_wdata  output  WIDTH  write data.
REQ-012 Port: core_rst  output  1  holds the subneg core in reset while high.
REQ-013 Port: load_done  output  1  level; image loaded and checksum matched.
REQ-014 Port: load_err  output  1  level; checksum mismatch.

Function
REQ-015 Handshake: a byte is consumed only in a cycle where in_valid=1 and in_ready=1; in_valid while in_ready=0 is ignored.
REQ-016 Stream format: length byte N, then N data bytes, then one checksum byte.
REQ-017 FSM states: IDLE, LEN, DATA, CSUM, DONE, ERR.
REQ-018 IDLE: in_ready=0, core_rst=1; start=1 -> LEN.
REQ-019 LEN: in_ready=1; on handshake, capture N, clear address counter and running sum; N=0 -> CSUM, else -> DATA.
REQ-020 DATA: in_ready=1; each handshake writes the byte to the current address, adds it to the running sum modulo 2^WIDTH, and increments the address; handshake on byte N -> CSUM.
REQ-021 Write latency: mem_we=1 for exactly one cycle, in the cycle after the data handshake; mem_addr/mem_wdata valid in that cycle; addresses run 0..N-1, no wrap (max N = 2^WIDTH-1).
REQ-022 mem_we=0 in every cycle not following a DATA handshake; mem_addr/mem_wdata hold their last values otherwise.
REQ-023 CSUM: in_ready=1; on handshake, byte equal to running sum -> DONE, otherwise -> ERR.
REQ-024 DONE: in_ready=0, core_rst=0, load_done=1, load_err=0.
REQ-025 ERR: in_ready=0, core_rst=1, load_err=1, load_done=0.
REQ-026 start=1 in DONE or ERR -> LEN next cycle; core_rst=1 and load_done/load_err=0 from that cycle on.
REQ-027 start is ignored in LEN, DATA and CSUM.
REQ-028 in_valid=1 with start=1 in IDLE: byte not consumed (in_ready=0 that cycle).
REQ-029 Back-to-back handshakes on consecutive cycles are supported without stalls; in_ready never drops within LEN/DATA/CSUM.
REQ-030 core_rst is registered, glitch-free, and deasserts only on entry to DONE.

Reset
REQ-031 rst=1 at a clock edge: state IDLE, in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, core_rst=1, load_done=0, load_err=0, running sum=0, counters=0.
REQ-032 rst takes priority over start and handshakes; rst mid-load aborts the session, and no mem_we is issued after the reset edge, including a write pending from the prior cycle's handshake.

Verification
REQ-033 Reset, then start, stream 03,10,20,30,60 back-to-back -> writes (0,10),(1,20),(2,30) one cycle after each handshake; DONE; core_rst=0, load_done=1.
REQ-034 Stream 02,FF,02,00 -> sum wraps to 01, checksum 00 mismatches -> ERR, load_err=1, core_rst=1, no further writes.
REQ-035 Stream 00,00 -> no mem_we; DONE.
REQ-036 Stream 02,AA,55,FF with in_valid toggled 1,0,1,0 between bytes -> identical writes (0,AA),(1,55); DONE; idle cycles consume nothing.
REQ-037 rst asserted in the cycle after the second data handshake of a 4-byte image -> no write for that byte or any later byte; IDLE, core_rst=1; new start reloads correctly.
REQ-038 From DONE, start with a new image -> core_rst rises the next cycle, load_done clears, new image overwrites addresses from 0.

Source files
------------

// File: rtl/subneg_loader_if.sv
// Host byte stream and core memory write port of the subneg image loader.
interface subneg_loader_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             mem_we;
  logic [WIDTH-1:0] mem_addr;
  logic [WIDTH-1:0] mem_wdata;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output mem_we,
    output mem_addr,
    output mem_wdata
  );
endinterface

// File: rtl/subneg_loader.sv
// Loads a length-prefixed, checksummed image from a byte stream into core
// memory and releases the subneg core from reset only once the image verifies.
module subneg_loader #(
  parameter int unsigned WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  subneg_loader_if.slave bus,
  output logic           core_rst,
  output logic           load_done,
  output logic           load_err
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] LEN  = 3'd1;
  localparam logic [2:0] DATA = 3'd2;
  localparam logic [2:0] CSUM = 3'd3;
  localparam logic [2:0] DONE = 3'd4;
  localparam logic [2:0] ERR  = 3'd5;

  logic [2:0]       state;
  logic [2:0]       state_nxt;
  logic [WIDTH-1:0] addr;
  logic [WIDTH-1:0] remain;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic             we_q;
  logic             ready;
  logic             hs;

  assign ready         = (state == LEN) || (state == DATA) || (state == CSUM);
  assign hs            = bus.in_valid && ready;
  assign bus.in_ready  = ready;
  assign bus.mem_addr  = wr_addr;
  assign bus.mem_wdata = wr_data;
  // A write registered on the last pre-reset edge must not reach memory while rst is high.
  assign bus.mem_we    = we_q && !rst;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = LEN;
      LEN:  if (hs) state_nxt = (bus.in_data == '0) ? CSUM : DATA;
      DATA: if (hs && (remain == WIDTH'(1))) state_nxt = CSUM;
      CSUM: if (hs) state_nxt = (bus.in_data == sum) ? DONE : ERR;
      DONE: if (start) state_nxt = LEN;
      ERR:  if (start) state_nxt = LEN;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      addr      <= '0;
      remain    <= '0;
      sum       <= '0;
      wr_addr   <= '0;
      wr_data   <= '0;
      we_q      <= 1'b0;
      core_rst  <= 1'b1;
      load_done <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      state     <= state_nxt;
      we_q      <= 1'b0;
      // Status flags are registered from the next state so they change with it.
      core_rst  <= (state_nxt != DONE);
      load_done <= (state_nxt == DONE);
      load_err  <= (state_nxt == ERR);
      if ((state == LEN) && hs) begin
        remain <= bus.in_data;
        addr   <= '0;
        sum    <= '0;
      end
      if ((state == DATA) && hs) begin
        we_q    <= 1'b1;
        wr_addr <= addr;
        wr_data <= bus.in_data;
        addr    <= addr + WIDTH'(1);
        sum     <= sum + bus.in_data;
        remain  <= remain - WIDTH'(1);
      end
    end
  end

endmodule
